flp_adder_arbiter: RTL
======================

Name: flp_adder_arbiter

Overview:
- Shares one pipelined FLPAdder instance among NUM_REQ requesters with round-robin arbitration. Issues at most one operation per cycle.
- Tracks in-flight operations with a requester-ID tag FIFO and routes each adder result back to the requester that issued it.
- Sits between NTT butterfly/twiddle control units and the floating-point adder. Throttles issue with an in-flight credit limit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_INFLIGHT, 8, tag FIFO depth = maximum outstanding operations (power of 2, ≥ adder latency).
- ADDER_LATENCY, 3, cycles from adder start to done; used only for post-reset done suppression.
- OVERALL_BITS, from FLP_pkg, operand/result width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_a  in  NUM_REQ*OVERALL_BITS  operand a; requester i occupies slice [i*OVERALL_BITS +: OVERALL_BITS]
- req_b  in  NUM_REQ*OVERALL_BITS  operand b; same packing as req_a
- req_ready  out  NUM_REQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
- resp_valid  out  NUM_REQ  one-hot, one-cycle result pulse to the owning requester
- resp_result  out  OVERALL_BITS  result, shared by all requesters, qualified by resp_valid
- adder_start  out  1  start pulse to the adder
- adder_a  out  OVERALL_BITS  adder operand a
- adder_b  out  OVERALL_BITS  adder operand b
- adder_result  in  OVERALL_BITS  adder result
- adder_done  in  1  adder result valid
- inflight  out  $clog2(MAX_INFLIGHT+1)  outstanding operation count
- err_spurious_done  out  1  sticky: adder_done arrived with the tag FIFO empty

Behaviour:
- Reset values:
  - All outputs 0. Round-robin pointer 0. Tag FIFO empty. Error flag cleared.
  - Suppression counter loaded with ADDER_LATENCY.
  - Reset is legal mid-operation. All in-flight operations are discarded and no resp_valid is generated for them.
- Post-reset suppression:
  - The adder has no reset, so adder_done is ignored while the suppression counter is nonzero.
  - The counter decrements each cycle. No grants are issued while it is nonzero (req_ready = 0).
- Arbitration (combinational):
  - Candidates are req_valid[i] when suppression = 0 and credit is available.
  - Credit is available when inflight < MAX_INFLIGHT, or when inflight == MAX_INFLIGHT and an accepted adder_done is present this cycle.
  - Search starts at the pointer and wraps modulo NUM_REQ. The first valid index is granted, giving a one-hot req_ready.
  - After a grant to index i, pointer <= (i+1) mod NUM_REQ. The pointer is unchanged when there is no grant.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Issue (1-cycle latency):
  - On a handshake at cycle t: at t+1, adder_start = 1, adder_a/adder_b = the granted operands, and tag i is pushed into the FIFO.
  - adder_start is 0 on cycles with no grant. adder_a/adder_b hold their last values.
- Return (1-cycle latency):
  - On an accepted adder_done at cycle t, the head tag j is popped.
  - At t+1: resp_valid[j] = 1 and resp_result = the adder_result captured at t.
  - Results return in issue order, because the adder is in-order.
- inflight:
  - +1 on handshake, −1 on accepted adder_done. A simultaneous handshake and done leaves it unchanged.
  - The FIFO push/pop bypass must be correct when the FIFO is full with a simultaneous pop and push.
  - The counter counts from handshake to adder_done; the response register is not counted.
- Spurious done: adder_done with the FIFO empty (and suppression = 0) sets err_spurious_done. No pop occurs and no resp_valid is generated.
- FIFO pointers: wrap modulo MAX_INFLIGHT, with an extra bit for the full/empty distinction. Overflow is impossible by the credit rule.
- Throughput: 1 op/cycle sustained once suppression has expired.

Test Plan:
- Reset, then requester 0 issues a=0x3FF0000000000000 (1.0), b=0x4000000000000000 (2.0) with the adder configured binary64, DO_SUBSTRACTION=0 -> no grant during the first 3 cycles; then adder_start one cycle after handshake; resp_valid=4'b0001 with resp_result=0x4008000000000000 (3.0) one cycle after adder_done.
- All 4 requesters hold req_valid for 8 cycles with pointer=0 -> grant order 0,1,2,3,0,1,2,3; each resp_valid pulse reaches the matching requester with its own a+b.
- Adder model stalls done (latency forced to 20), 12 continuous requests -> exactly 8 grants, then req_ready=0, inflight=8; the first done re-enables a grant in the same cycle and inflight stays 8.
- adder_done pulsed with an empty FIFO after suppression -> err_spurious_done=1 and stays set; no resp_valid.
- Assert rst while inflight=5, with done pulses arriving 1-3 cycles later -> outputs 0, dones ignored, inflight=0, no resp_valid, no error.
- Only requester 2 valid while pointer=3 -> grant to 2 (wrap-around), pointer becomes 3.

Source files
------------

// File: rtl/flp_adder_arbiter.sv
// flp_adder_arbiter: round-robin sharing of one pipelined FLPAdder among
// NUM_REQ requesters, with a requester-ID tag FIFO for result routing.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   req_valid/a/b      per-requester operation request and packed operands
//   req_ready          one-hot grant (combinational, may depend on req_valid)
//   resp_valid         one-hot, one-cycle result pulse to the owning requester
//   resp_result        shared result bus, qualified by resp_valid
//   adder_start/a/b    registered issue to the adder
//   adder_result/done  adder return path
//   inflight           operations between handshake and accepted done
//   err_spurious_done  sticky: adder_done seen with no operation outstanding

package FLP_pkg;
    localparam int OVERALL_BITS = 64;
endpackage

module flp_adder_arbiter
    import FLP_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int MAX_INFLIGHT  = 8,
    parameter int ADDER_LATENCY = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*OVERALL_BITS-1:0]   req_a,
    input  logic [NUM_REQ*OVERALL_BITS-1:0]   req_b,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                resp_valid,
    output logic [OVERALL_BITS-1:0]           resp_result,
    output logic                              adder_start,
    output logic [OVERALL_BITS-1:0]           adder_a,
    output logic [OVERALL_BITS-1:0]           adder_b,
    input  logic [OVERALL_BITS-1:0]           adder_result,
    input  logic                              adder_done,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              err_spurious_done
);

    localparam int W     = OVERALL_BITS;
    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW    = $clog2(MAX_INFLIGHT);
    localparam int PW    = AW + 1;
    localparam int IW    = $clog2(MAX_INFLIGHT + 1);
    localparam int SW    = $clog2(ADDER_LATENCY + 1);

    // Registered state
    logic [SW-1:0]      supp_q, supp_d;
    logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]      inflight_q, inflight_d;
    logic               start_q, start_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [W-1:0]       resp_result_q, resp_result_d;
    logic               err_q, err_d;
    logic [TAG_W-1:0]   tag_mem_q [MAX_INFLIGHT];

    // Combinational control
    logic               supp_active;
    logic               fifo_empty;
    logic               done_acc;
    logic               done_spur;
    logic               credit;
    logic [TAG_W-1:0]   head_tag;
    logic [TAG_W-1:0]   cand;
    logic [TAG_W-1:0]   grant_idx;
    logic               grant_vld;
    logic [NUM_REQ-1:0] grant;

    // The adder has no reset, so its done line is meaningless until any
    // operation that was in its pipeline at reset time has drained out.
    assign supp_active = (supp_q != '0);
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign done_acc    = adder_done & ~supp_active & ~fifo_empty;
    assign done_spur   = adder_done & ~supp_active & fifo_empty;
    assign head_tag    = tag_mem_q[rd_ptr_q[AW-1:0]];

    // A done accepted this cycle frees a slot, so a full FIFO may still
    // take a new operation in the same cycle.
    assign credit = (inflight_q < IW'(MAX_INFLIGHT)) | done_acc;

    // Round-robin search starting at the pointer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        if (!supp_active && credit) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = TAG_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (!grant_vld && req_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        supp_d        = supp_active ? supp_q - SW'(1) : supp_q;
        rr_ptr_d      = rr_ptr_q;
        wr_ptr_d      = wr_ptr_q + PW'(grant_vld);
        rd_ptr_d      = rd_ptr_q + PW'(done_acc);
        inflight_d    = inflight_q;
        start_d       = grant_vld;
        a_d           = a_q;
        b_d           = b_q;
        resp_valid_d  = '0;
        resp_result_d = resp_result_q;
        err_d         = err_q | done_spur;

        if (grant_vld) begin
            rr_ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0
                                                          : grant_idx + TAG_W'(1);
            a_d      = req_a[int'(grant_idx)*W +: W];
            b_d      = req_b[int'(grant_idx)*W +: W];
        end

        // Simultaneous issue and retire leaves the count unchanged.
        if (grant_vld && !done_acc) begin
            inflight_d = inflight_q + IW'(1);
        end else if (!grant_vld && done_acc) begin
            inflight_d = inflight_q - IW'(1);
        end

        if (done_acc) begin
            resp_valid_d[head_tag] = 1'b1;
            resp_result_d          = adder_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            supp_q        <= SW'(ADDER_LATENCY);
            rr_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            inflight_q    <= '0;
            start_q       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            err_q         <= 1'b0;
        end else begin
            supp_q        <= supp_d;
            rr_ptr_q      <= rr_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            inflight_q    <= inflight_d;
            start_q       <= start_d;
            a_q           <= a_d;
            b_q           <= b_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            err_q         <= err_d;
        end
    end

    // Tag storage needs no reset: the pointers define which entries are live.
    // When full, the write slot equals the head slot; the head is read
    // before the edge, so a same-cycle pop and push is safe.
    always_ff @(posedge clk) begin
        if (grant_vld) begin
            tag_mem_q[wr_ptr_q[AW-1:0]] <= grant_idx;
        end
    end

    assign req_ready         = grant;
    assign resp_valid        = resp_valid_q;
    assign resp_result       = resp_result_q;
    assign adder_start       = start_q;
    assign adder_a           = a_q;
    assign adder_b           = b_q;
    assign inflight          = inflight_q;
    assign err_spurious_done = err_q;

endmodule
